// File: rtl/reorder_buffer.sv
`default_nettype none
// ============================================================================
//  Module   : reorder_buffer
//  Brief    : Circular in-order reorder buffer. Allocates tags at issue,
//             captures CDB results out of order, retires one entry per cycle
//             in program order (register commit, store release, flush).
//  Revision : 1.0 - initial release
// ============================================================================
module reorder_buffer #(
    parameter int ROB_WIDTH = 4
) (
    input  logic                 clk_in,
    input  logic                 rst_in,
    input  logic                 rdy_in,
    input  logic                 issue_signal,
    input  logic [1:0]           issue_type,
    input  logic [4:0]           issue_rd,
    input  logic                 issue_pred_taken,
    output logic [ROB_WIDTH-1:0] issue_tag,
    output logic                 rob_full,
    input  logic                 cdb_signal,
    input  logic [ROB_WIDTH-1:0] cdb_tag,
    input  logic [31:0]          cdb_value,
    input  logic                 cdb_taken,
    input  logic [31:0]          cdb_target,
    input  logic [ROB_WIDTH-1:0] query_tag_1,
    input  logic [ROB_WIDTH-1:0] query_tag_2,
    output logic                 query_ready_1,
    output logic                 query_ready_2,
    output logic [31:0]          query_value_1,
    output logic [31:0]          query_value_2,
    output logic                 rob_commit_signal,
    output logic [4:0]           commit_rd_id,
    output logic [ROB_WIDTH-1:0] commit_rd_tag,
    output logic [31:0]          commit_rd_value,
    output logic                 store_commit_signal,
    output logic                 clear_signal,
    output logic [31:0]          clear_pc
);

    localparam int                 c_DEPTH     = 1 << ROB_WIDTH;
    localparam logic [ROB_WIDTH:0] c_DEPTH_CNT = (ROB_WIDTH+1)'(c_DEPTH);
    localparam logic [1:0]         c_TYPE_BR   = 2'd1;
    localparam logic [1:0]         c_TYPE_ST   = 2'd2;

    // Control state (reset)
    logic [ROB_WIDTH-1:0] r_head;
    logic [ROB_WIDTH-1:0] r_tail;
    logic [ROB_WIDTH:0]   r_count;
    logic [c_DEPTH-1:0]   r_busy;
    logic [c_DEPTH-1:0]   r_ready;

    // Entry payload (no reset needed: only read once busy/ready are set)
    logic [1:0]           r_type   [c_DEPTH];
    logic [4:0]           r_rd     [c_DEPTH];
    logic                 r_pred   [c_DEPTH];
    logic                 r_taken  [c_DEPTH];
    logic [31:0]          r_value  [c_DEPTH];
    logic [31:0]          r_target [c_DEPTH];

    logic w_issue;
    logic w_cdb;
    logic w_commit;
    logic w_mispredict;

    assign issue_tag = r_tail;
    assign rob_full  = (r_count == c_DEPTH_CNT);

    // Nothing is accepted during the one flush cycle; the full flag is the
    // one sampled this cycle, so an issue coinciding with a retire while
    // full is still rejected.
    assign w_issue      = issue_signal && !rob_full && !clear_signal;
    assign w_cdb        = cdb_signal && r_busy[cdb_tag] && !clear_signal;
    assign w_commit     = !clear_signal && r_busy[r_head] && r_ready[r_head];
    assign w_mispredict = w_commit && (r_type[r_head] == c_TYPE_BR) &&
                          (r_taken[r_head] != r_pred[r_head]);

    // Pointers, occupancy flags and registered retire outputs
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            r_head              <= '0;
            r_tail              <= '0;
            r_count             <= '0;
            r_busy              <= '0;
            r_ready             <= '0;
            rob_commit_signal   <= 1'b0;
            commit_rd_id        <= '0;
            commit_rd_tag       <= '0;
            commit_rd_value     <= '0;
            store_commit_signal <= 1'b0;
            clear_signal        <= 1'b0;
            clear_pc            <= '0;
        end else if (rdy_in) begin
            rob_commit_signal   <= 1'b0;
            store_commit_signal <= 1'b0;
            clear_signal        <= 1'b0;
            if (w_mispredict) begin
                // Flush wipes every in-flight entry; this edge's issue/CDB are dropped
                r_head       <= '0;
                r_tail       <= '0;
                r_count      <= '0;
                r_busy       <= '0;
                r_ready      <= '0;
                clear_signal <= 1'b1;
                clear_pc     <= r_target[r_head];
            end else begin
                if (w_cdb) begin
                    r_ready[cdb_tag] <= 1'b1;
                end
                if (w_issue) begin
                    r_busy[r_tail]  <= 1'b1;
                    r_ready[r_tail] <= 1'b0;
                    r_tail          <= r_tail + ROB_WIDTH'(1);
                end
                if (w_commit) begin
                    r_busy[r_head]  <= 1'b0;
                    r_ready[r_head] <= 1'b0;
                    r_head          <= r_head + ROB_WIDTH'(1);
                    if (r_type[r_head] == c_TYPE_ST) begin
                        store_commit_signal <= 1'b1;
                    end else if (r_type[r_head] != c_TYPE_BR) begin
                        // Reserved type 3 retires as a register write
                        rob_commit_signal <= 1'b1;
                        commit_rd_id      <= r_rd[r_head];
                        commit_rd_tag     <= r_head;
                        commit_rd_value   <= r_value[r_head];
                    end
                end
                r_count <= r_count + (ROB_WIDTH+1)'(w_issue) - (ROB_WIDTH+1)'(w_commit);
            end
        end
    end

    // Entry payload capture at issue and at CDB writeback
    always_ff @(posedge clk_in) begin
        if (rdy_in && !w_mispredict) begin
            if (w_issue) begin
                r_type[r_tail] <= issue_type;
                r_rd[r_tail]   <= issue_rd;
                r_pred[r_tail] <= issue_pred_taken;
            end
            if (w_cdb) begin
                r_value[cdb_tag]  <= cdb_value;
                r_taken[cdb_tag]  <= cdb_taken;
                r_target[cdb_tag] <= cdb_target;
            end
        end
    end

    // Operand forwarding: a same-cycle CDB broadcast wins over stored values
    always_comb begin
        query_ready_1 = 1'b0;
        query_value_1 = '0;
        query_ready_2 = 1'b0;
        query_value_2 = '0;
        if (cdb_signal && (cdb_tag == query_tag_1)) begin
            query_ready_1 = 1'b1;
            query_value_1 = cdb_value;
        end else if (r_ready[query_tag_1]) begin
            query_ready_1 = 1'b1;
            query_value_1 = r_value[query_tag_1];
        end
        if (cdb_signal && (cdb_tag == query_tag_2)) begin
            query_ready_2 = 1'b1;
            query_value_2 = cdb_value;
        end else if (r_ready[query_tag_2]) begin
            query_ready_2 = 1'b1;
            query_value_2 = r_value[query_tag_2];
        end
    end

endmodule
`default_nettype wire

// File: doc/reorder_buffer.md
Name: reorder_buffer

Overview:
- Circular in-order reorder buffer (ROB) of 2^ROB_WIDTH entries; sits downstream of issue and the CDB, upstream of register_file.
- Allocates a tag per issued instruction and captures CDB results out of order.
- Retires one entry per cycle in program order, driving the register-file commit port (rob_commit_signal / commit_rd_tag / commit_rd_value), store release, and branch-misprediction flush (clear_signal).

Parameters:
ROB_WIDTH, 4, tag width; DEPTH = 2^ROB_WIDTH entries

Ports:
clk_in  in  1  system clock
rst_in  in  1  asynchronous active-high reset
rdy_in  in  1  global pause; low freezes all state and holds all registered outputs
issue_signal  in  1  allocate entry at tail this cycle
issue_type  in  2  0=reg write, 1=branch, 2=store, 3=reserved (treated as 0)
issue_rd  in  5  destination register (type 0)
issue_pred_taken  in  1  predicted direction (type 1)
issue_tag  out  ROB_WIDTH  tag of next allocation = tail (combinational)
rob_full  out  1  count == DEPTH (combinational)
cdb_signal  in  1  result broadcast valid
cdb_tag  in  ROB_WIDTH  producing entry
cdb_value  in  32  result value
cdb_taken  in  1  actual branch direction
cdb_target  in  32  correct next PC if mispredicted
query_tag_1, query_tag_2  in  ROB_WIDTH  operand tags from issue
query_ready_1, query_ready_2  out  1  operand value available (combinational)
query_value_1, query_value_2  out  32  operand value (combinational)
rob_commit_signal  out  1  register commit pulse
commit_rd_id  out  5  committed rd
commit_rd_tag  out  ROB_WIDTH  committed tag (head index)
commit_rd_value  out  32  committed value
store_commit_signal  out  1  release head store to LSB
clear_signal  out  1  misprediction flush pulse
clear_pc  out  32  redirect PC, valid with clear_signal

Behaviour:
- State:
  - head, tail: ROB_WIDTH bits, wrap naturally mod DEPTH.
  - count: ROB_WIDTH+1 bits.
  - Per entry: busy, ready, type, rd, value, pred_taken, taken, target.
- Reset (async, rst_in=1): head=tail=count=0; all busy/ready=0; all registered outputs 0.
- rdy_in=0: no state update; outputs hold.
- Issue (edge, rdy_in=1, issue_signal=1, !rob_full, !clear_signal):
  - Entry[tail] gets busy=1, ready=0, plus type/rd/pred_taken.
  - tail+1.
  - Issue while full is ignored.
- CDB (edge, cdb_signal=1, entry busy): entry[cdb_tag] gets ready=1 and value/taken/target. A CDB write to a non-busy entry is ignored.
- Commit (edge, rdy_in=1, !clear_signal, entry[head] busy and ready at start of cycle):
  - Free head; head+1.
  - Outputs, registered, high exactly one cycle unless another commit follows:
    - type 0: rob_commit_signal=1; commit_rd_id, commit_rd_tag=old head, commit_rd_value.
    - type 2: store_commit_signal=1.
    - type 1 with taken==pred_taken: no pulse.
    - type 1 with taken!=pred_taken: clear_signal=1, clear_pc=target.
  - Otherwise all pulses return to 0.
- Latency:
  - CDB-to-commit is at least 1 cycle: a CDB write to head at edge N is visible at edge N+1, and the commit pulse is valid in cycle N+2.
  - Throughput: one retire per cycle.
- Simultaneous events:
  - Issue+commit in the same cycle: count unchanged; legal when full, since the issue is still rejected on the full flag sampled that cycle.
  - CDB+commit of a different entry in the same cycle: both take effect.
- Flush:
  - The edge that registers clear_signal=1 also resets head=tail=count=0 and all busy=0; that edge's issue and CDB inputs are discarded.
  - While clear_signal=1 (one cycle), issue, CDB and commit are ignored.
  - clear_signal drops the following cycle unless rdy_in is low, in which case it holds.
- Query forwarding:
  - query_ready_k = entry[query_tag_k].ready OR (cdb_signal AND cdb_tag==query_tag_k).
  - The CDB value takes priority.
  - Value is 0 when not ready.
- Tag reuse: issue_tag may equal a tag still held in register_file; safe because that entry was already committed.

Test Plan:
- Reset then issue type 0 rd=5 → issue_tag=0. CDB tag 0, value 0x1234 → two cycles later rob_commit_signal=1, commit_rd_id=5, commit_rd_tag=0, commit_rd_value=0x1234; one cycle wide.
- Out-of-order writeback: issue tags 0,1,2, CDB order 2,1,0 → commits in order 0,1,2 on consecutive cycles.
- Fill 16 entries without CDB → rob_full=1; a 17th issue is ignored (tail stays 0). Then CDB tag 0 → commit; full drops, next issue_tag=0 (wrap).
- Branch: pred_taken=0, CDB taken=1, target 0x100; younger entries in flight → at commit, clear_signal=1, clear_pc=0x100. Next cycle count=0, issue_tag=0, and CDB to an old tag is ignored.
- Forwarding: entry 3 ready with 0xAA → query_tag_1=3 gives ready=1, value 0xAA. CDB tag 4, value 0xBB in the same cycle as query_tag_2=4 → ready=1, value 0xBB.
- Assert rst_in asynchronously mid-run with pulses high → outputs 0 immediately; hold rdy_in low with rob_commit_signal=1 → signal and head frozen.
